// File: rtl/clock_divider_prog.sv
// -----------------------------------------------------------------------------
// clock_divider_prog
//
// Run-time programmable clock divider / clock-enable generator. Divides clk
// by an integer N in [2, 2**WIDTH-1] and produces a registered, roughly 50%
// duty output plus a one-cycle tick on the first cycle of every period. A new
// divisor is staged in a pending register. It is only promoted at a period
// boundary, so the period already in progress is never cut short or
// stretched.
//
// Parameters
//   WIDTH        width of divisor, pending/active registers and counter
//   DEFAULT_DIV  divisor in force after reset (must be >= 2)
//
// Ports
//   clk      in   1      system clock, all state updates on posedge
//   rst      in   1      asynchronous, active-high reset
//   en       in   1      count enable; low freezes cnt, act_div and out_d
//   load     in   1      sample div into the pending register (ignores en)
//   div      in   WIDTH  requested divisor N (values < 2 are clamped to 2)
//   out_d    out  1      divided clock, straight from a flop
//   tick     out  1      one-cycle pulse on the first cycle of each period
//   cnt      out  WIDTH  current phase, 0 .. act_div-1
//   cfg_err  out  1      sticky flag: a load with div < 2 was seen
//
// Valid/ready: there is no handshake. load is a single-cycle strobe that is
// always accepted. div is sampled on every posedge where load is high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module clock_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
    output logic             out_d,
    output logic             tick,
    output logic [WIDTH-1:0] cnt,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] act_div_q,  act_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             out_d_q,    out_d_d;
    logic             tick_q,     tick_d;
    logic             cfg_err_q,  cfg_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] div_clamped;
    logic             div_bad;
    logic             wrap;
    logic [WIDTH-1:0] high_from;

    always_comb begin
        div_clamped = (div < MIN_DIV) ? MIN_DIV : div;
        div_bad     = load && (div < MIN_DIV);
        // act_div_q is always >= 2, so act_div_q - 1 never underflows.
        wrap        = (cnt_q == (act_div_q - ONE));
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        pend_div_d = pend_div_q;
        tick_d     = 1'b0;
        cfg_err_d  = cfg_err_q | div_bad;
        high_from  = '0;
        out_d_d    = 1'b0;

        // The pending register is loaded whether or not counting is enabled.
        if (load) begin
            pend_div_d = div_clamped;
        end

        if (en) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                // A load on the wrap cycle itself must take effect for the
                // period that starts now. The pending register would only
                // see the new value one cycle too late.
                act_div_d = load ? div_clamped : pend_div_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        // out_d is registered from the next-state phase and divisor. The
        // flop therefore always agrees with the cnt/act_div values that
        // are visible in the same cycle. The low half gets the extra
        // cycle for odd N.
        high_from = act_div_d - (act_div_d >> 1);
        out_d_d   = (cnt_d >= high_from);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            act_div_q  <= DIV_RST;
            pend_div_q <= DIV_RST;
            out_d_q    <= 1'b0;
            tick_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            pend_div_q <= pend_div_d;
            out_d_q    <= out_d_d;
            tick_q     <= tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_d   = out_d_q;
    assign tick    = tick_q;
    assign cnt     = cnt_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_prog
//
// Directed bench for clock_divider_prog (WIDTH=8, DEFAULT_DIV=2). Every
// expected cnt/out_d/tick/cfg_err value below is hand-derived from the
// divider's behaviour and written out cycle by cycle. Inputs change and
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clock_divider_prog;

    localparam int WIDTH = 8;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div;
    logic             out_d;
    logic             tick;
    logic [WIDTH-1:0] cnt;
    logic             cfg_err;

    always #5 clk = ~clk;

    clock_divider_prog #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .div    (div),
        .out_d  (out_d),
        .tick   (tick),
        .cnt    (cnt),
        .cfg_err(cfg_err)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and the single checking task
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    // Advance one rising edge and land 1 ns after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge, then check cnt, out_d and tick.
    task automatic step_chk(input string tag, input int e_cnt, input int e_out, input int e_tick);
        edge_step();
        check({tag, "_cnt"},  32'(cnt),   32'(e_cnt));
        check({tag, "_out"},  32'(out_d), 32'(e_out));
        check({tag, "_tick"}, 32'(tick),  32'(e_tick));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        div  = '0;

        // Reset state
        edge_step();
        edge_step();
        check("rst_cnt",     32'(cnt),     32'd0);
        check("rst_out",     32'(out_d),   32'd0);
        check("rst_tick",    32'(tick),    32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        edge_step();
        // With en low, nothing moves after reset is released.
        check("idle_cnt", 32'(cnt), 32'd0);

        // 1. Default N=2: behaves like the legacy divide-by-2.
        en = 1'b1;
        step_chk("n2_a", 1, 1, 0);
        step_chk("n2_b", 0, 0, 1);
        step_chk("n2_c", 1, 1, 0);
        step_chk("n2_d", 0, 0, 1);

        // 2. load 5 at cnt=0 of an N=2 period. The current 2-cycle period
        //    completes first, then the pattern becomes 0,0,0,1,1.
        load = 1'b1; div = 8'd5;
        step_chk("n5_pre", 1, 1, 0);
        load = 1'b0; div = 8'd0;
        step_chk("n5_w0", 0, 0, 1);
        step_chk("n5_c1", 1, 0, 0);
        step_chk("n5_c2", 2, 0, 0);
        step_chk("n5_c3", 3, 1, 0);
        step_chk("n5_c4", 4, 1, 0);
        step_chk("n5_w1", 0, 0, 1);

        // 4. en low for 3 cycles at cnt=2 of N=5: everything freezes.
        step_chk("frz_c1", 1, 0, 0);
        step_chk("frz_c2", 2, 0, 0);
        en = 1'b0;
        step_chk("frz_h0", 2, 0, 0);
        step_chk("frz_h1", 2, 0, 0);
        step_chk("frz_h2", 2, 0, 0);
        en = 1'b1;
        step_chk("frz_c3", 3, 1, 0);
        step_chk("frz_c4", 4, 1, 0);
        step_chk("frz_w",  0, 0, 1);

        // 3. Set up N=4 and then load 7 on the exact wrap cycle of N=4.
        load = 1'b1; div = 8'd4;
        step_chk("n4_s1", 1, 0, 0);
        load = 1'b0;
        step_chk("n4_s2", 2, 0, 0);
        step_chk("n4_s3", 3, 1, 0);
        step_chk("n4_s4", 4, 1, 0);
        step_chk("n4_w0", 0, 0, 1);
        step_chk("n4_c1", 1, 0, 0);
        step_chk("n4_c2", 2, 1, 0);
        step_chk("n4_c3", 3, 1, 0);
        load = 1'b1; div = 8'd7;        // cnt == 3 == act_div-1: the wrap cycle
        step_chk("n7_w0", 0, 0, 1);
        load = 1'b0; div = 8'd0;
        step_chk("n7_c1", 1, 0, 0);
        step_chk("n7_c2", 2, 0, 0);
        step_chk("n7_c3", 3, 0, 0);
        step_chk("n7_c4", 4, 1, 0);
        step_chk("n7_c5", 5, 1, 0);
        step_chk("n7_c6", 6, 1, 0);
        step_chk("n7_w1", 0, 0, 1);

        // 5. Illegal divisors 0 and 1: clamped to 2, cfg_err is sticky.
        check("err_before", 32'(cfg_err), 32'd0);
        load = 1'b1; div = 8'd0;
        step_chk("err_c1", 1, 0, 0);
        check("err_div0", 32'(cfg_err), 32'd1);
        div = 8'd1;
        step_chk("err_c2", 2, 0, 0);
        check("err_div1", 32'(cfg_err), 32'd1);
        load = 1'b0; div = 8'd9;        // div changes without load: ignored
        step_chk("err_c3", 3, 0, 0);
        step_chk("err_c4", 4, 1, 0);
        step_chk("err_c5", 5, 1, 0);
        step_chk("err_c6", 6, 1, 0);
        step_chk("err_w0", 0, 0, 1);    // act_div now 2
        step_chk("err_n2a", 1, 1, 0);
        step_chk("err_n2b", 0, 0, 1);
        check("err_sticky", 32'(cfg_err), 32'd1);

        // Load is honoured while en is low; the held state does not move.
        en = 1'b0; load = 1'b1; div = 8'd255;
        step_chk("ld_off", 0, 0, 0);
        load = 1'b0; div = 8'd0; en = 1'b1;
        step_chk("n255_pre", 1, 1, 0);  // finishes the N=2 period
        step_chk("n255_w0", 0, 0, 1);   // act_div now 255

        // 6. Run N=255 to cnt=100, then assert rst between edges.
        for (int i = 1; i <= 100; i++) begin
            edge_step();
        end
        check("n255_cnt100",  32'(cnt),   32'd100);
        check("n255_out100",  32'(out_d), 32'd0);    // high only from cnt 128
        check("n255_tick100", 32'(tick),  32'd0);
        for (int i = 101; i <= 130; i++) begin
            edge_step();
        end
        check("n255_cnt130", 32'(cnt),   32'd130);
        check("n255_out130", 32'(out_d), 32'd1);
        #2;
        rst = 1'b1;                      // asynchronous, mid-cycle
        #1;
        check("arst_cnt",     32'(cnt),     32'd0);
        check("arst_out",     32'(out_d),   32'd0);
        check("arst_tick",    32'(tick),    32'd0);
        check("arst_cfg_err", 32'(cfg_err), 32'd0);
        edge_step();
        rst = 1'b0;
        // act_div is back to 2: period of 2 from the first enabled edge.
        step_chk("post_a", 1, 1, 0);
        step_chk("post_b", 0, 0, 1);
        step_chk("post_c", 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
